// File: rtl/ibuf_mc_fifo_pkg.sv
// Shared router parameters: payload width, direction bit indices, and
// the helpers used by the multicast input buffer.
`ifndef IBUF_MC_FIFO_DEFS
`define IBUF_MC_FIFO_DEFS
`define PKT_W 32
`define DIR_N 0
`define DIR_S 1
`define DIR_E 2
`define DIR_W 3
`define DIR_B 4
`endif

package ibuf_mc_fifo_pkg;

    localparam int DIR_CNT = 5;

    typedef enum logic [2:0] {
        DIR_IDX_N = 3'(`DIR_N),
        DIR_IDX_S = 3'(`DIR_S),
        DIR_IDX_E = 3'(`DIR_E),
        DIR_IDX_W = 3'(`DIR_W),
        DIR_IDX_B = 3'(`DIR_B)
    } dir_e;

    function automatic logic [DIR_CNT-1:0] dir_bit(input dir_e d);
        logic [DIR_CNT-1:0] m;
        m = '0;
        m[d] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/ibuf_mc_fifo_if.sv
// Handshake bundle between the link receiver, the input buffer and the
// per-output crossbar arbiters.
interface ibuf_mc_fifo_if
    import ibuf_mc_fifo_pkg::*;
#(
    parameter int PYLD_W = `PKT_W,
    parameter int NDIR   = DIR_CNT,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              ibuf_vld;
    logic              ibuf_rdy;
    logic [NDIR-1:0]   route_req;
    logic [PYLD_W-1:0] payload_i;
    logic [NDIR-1:0]   arb_req;
    logic [NDIR-1:0]   arb_gnt;
    logic [NDIR-1:0]   obuf_rdy;
    logic [PYLD_W-1:0] payload_o;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  ibuf_vld, route_req, payload_i, arb_gnt, obuf_rdy,
        output ibuf_rdy, arb_req, payload_o, occ, drop_cnt
    );

    modport master (
        output ibuf_vld, route_req, payload_i, arb_gnt, obuf_rdy,
        input  ibuf_rdy, arb_req, payload_o, occ, drop_cnt
    );
endinterface

// File: rtl/ibuf_mc_fifo_ram.sv
// Entry storage for the input buffer: one write port, asynchronous read of
// the head payload plus the route mask of the entry behind the head.
module ibuf_ram
    import ibuf_mc_fifo_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NDIR   = DIR_CNT,
    parameter int PYLD_W = `PKT_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [NDIR-1:0]   wroute_i,
    input  logic [PYLD_W-1:0] wpyld_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [PYLD_W-1:0] rpyld_o,
    output logic [NDIR-1:0]   nxt_route_o
);
    localparam int W = NDIR + PYLD_W;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] nxt_addr;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= {wroute_i, wpyld_i};
        end
    end

    // The successor's route lets the head mask reload on the pop edge itself.
    assign nxt_addr    = raddr_i + AW'(1);
    assign rpyld_o     = mem_q[raddr_i][PYLD_W-1:0];
    assign nxt_route_o = mem_q[nxt_addr][W-1:PYLD_W];
endmodule

// File: rtl/ibuf_mc_fifo.sv
// Multi-entry router input buffer: holds packets with their direction masks
// and releases the head only after every requested direction is served.
module ibuf_mc_fifo
    import ibuf_mc_fifo_pkg::*;
#(
    parameter int PYLD_W = `PKT_W,
    parameter int NDIR   = DIR_CNT,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ibuf_mc_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [NDIR-1:0]   hd_mask_q, hd_mask_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [PYLD_W-1:0] last_pl_q, last_pl_d;

    logic              empty, accept, push, drop, pop;
    logic [NDIR-1:0]   clr, rem, nxt_route;
    logic [PYLD_W-1:0] rd_pyld;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    ibuf_ram #(
        .DEPTH (DEPTH),
        .NDIR  (NDIR),
        .PYLD_W(PYLD_W)
    ) u_ram (
        .clk        (clk),
        .we_i       (push),
        .waddr_i    (wr_ptr_q),
        .wroute_i   (bus.route_req),
        .wpyld_i    (bus.payload_i),
        .raddr_i    (rd_ptr_q),
        .rpyld_o    (rd_pyld),
        .nxt_route_o(nxt_route)
    );

    // Ready comes from the occupancy register only, so a full buffer refuses
    // a push even in a cycle where the head pops.
    assign empty        = (occ_q == '0);
    assign bus.ibuf_rdy = (occ_q != OW'(DEPTH));
    assign accept       = bus.ibuf_vld & bus.ibuf_rdy;
    assign push         = accept & (|bus.route_req);
    assign drop         = accept & ~(|bus.route_req);

    assign bus.arb_req  = empty ? '0 : hd_mask_q;
    assign clr          = bus.arb_gnt & bus.obuf_rdy & bus.arb_req;
    assign rem          = hd_mask_q & ~clr;
    assign pop          = !empty && (rem == '0);

    assign bus.payload_o = empty ? last_pl_q : rd_pyld;
    assign bus.occ       = occ_q;
    assign bus.drop_cnt  = drop_cnt_q;

    always_comb begin
        hd_mask_d  = rem;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        last_pl_d  = empty ? last_pl_q : rd_pyld;

        // On pop the mask reloads from whichever entry becomes head.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (occ_q >= OW'(2)) begin
                hd_mask_d = nxt_route;
            end else if (push) begin
                hd_mask_d = bus.route_req;
            end else begin
                hd_mask_d = '0;
            end
        end else if (empty && push) begin
            hd_mask_d = bus.route_req;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OW'(1);
        end

        if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            hd_mask_q  <= '0;
            drop_cnt_q <= '0;
            last_pl_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            hd_mask_q  <= hd_mask_d;
            drop_cnt_q <= drop_cnt_d;
            last_pl_q  <= last_pl_d;
        end
    end
endmodule

// File: tb/tb_ibuf_mc_fifo.sv
// Bench for the multicast input buffer: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_ibuf_mc_fifo;
    import ibuf_mc_fifo_pkg::*;

    localparam int PW = 32;
    localparam int ND = 5;
    localparam int DP = 4;
    localparam int CW = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibuf_mc_fifo_if #(.PYLD_W(PW), .NDIR(ND), .DEPTH(DP), .CNT_W(CW)) bus ();

    ibuf_mc_fifo #(.PYLD_W(PW), .NDIR(ND), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [ND-1:0] owed;
        logic [PW-1:0] pl;
    } ent_t;

    ent_t        mq[$];
    int          mdrop;
    logic [PW-1:0] mlast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            vld;
        logic [ND-1:0] route;
        logic [PW-1:0] pl;
        logic [ND-1:0] gnt;
        logic [ND-1:0] obuf;
        logic [ND-1:0] e_arb;
        int            e_occ;
        logic [PW-1:0] e_pl;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mdrop = 0;
        mlast = '0;
    endtask

    task automatic model_check();
        chk("m_arb_req", 64'(bus.arb_req), (mq.size() != 0) ? 64'(mq[0].owed) : 64'd0);
        chk("m_payload", 64'(bus.payload_o), (mq.size() != 0) ? 64'(mq[0].pl) : 64'(mlast));
        chk("m_occ", 64'(bus.occ), 64'(mq.size()));
        chk("m_rdy", 64'(bus.ibuf_rdy), 64'(mq.size() < DP));
        chk("m_drop", 64'(bus.drop_cnt), 64'(mdrop));
    endtask

    // One clock edge of the reference: serve the head, then accept input.
    task automatic model_step(input bit v, input logic [ND-1:0] r, input logic [PW-1:0] p,
                              input logic [ND-1:0] g, input logic [ND-1:0] o);
        bit rdy_m;
        rdy_m = (mq.size() < DP);
        if (mq.size() != 0) begin
            mq[0].owed = mq[0].owed & ~(g & o);
            if (mq[0].owed == '0) begin
                mlast = mq[0].pl;
                void'(mq.pop_front());
            end
        end
        if (v && rdy_m) begin
            if (r != '0) mq.push_back('{owed: r, pl: p});
            else if (mdrop < DROP_MAX) mdrop++;
        end
    endtask

    task automatic sample(input bit v, input logic [ND-1:0] r, input logic [PW-1:0] p,
                          input logic [ND-1:0] g, input logic [ND-1:0] o);
        @(negedge clk);
        bus.ibuf_vld  = v;
        bus.route_req = r;
        bus.payload_i = p;
        bus.arb_gnt   = g;
        bus.obuf_rdy  = o;
        #1;
        model_check();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step(bus.ibuf_vld, bus.route_req, bus.payload_i, bus.arb_gnt, bus.obuf_rdy);
    endtask

    task automatic apply(input bit v, input logic [ND-1:0] r, input logic [PW-1:0] p,
                         input logic [ND-1:0] g, input logic [ND-1:0] o);
        sample(v, r, p, g, o);
        edge_step();
    endtask

    initial begin
        bus.ibuf_vld  = 1'b0;
        bus.route_req = '0;
        bus.payload_i = '0;
        bus.arb_gnt   = '0;
        bus.obuf_rdy  = '0;
        model_reset();

        tbl[0]  = '{1'b1, 5'b00001, 32'hA1, 5'b00001, 5'b00001, 5'b00000, 0, 32'h0};
        tbl[1]  = '{1'b0, 5'b00000, 32'h0,  5'b00001, 5'b00001, 5'b00001, 1, 32'hA1};
        tbl[2]  = '{1'b0, 5'b00000, 32'h0,  5'b00001, 5'b00001, 5'b00000, 0, 32'hA1};
        tbl[3]  = '{1'b1, 5'b10110, 32'hB2, 5'b00000, 5'b00000, 5'b00000, 0, 32'hA1};
        tbl[4]  = '{1'b0, 5'b00000, 32'h0,  5'b00010, 5'b11111, 5'b10110, 1, 32'hB2};
        tbl[5]  = '{1'b0, 5'b00000, 32'h0,  5'b10000, 5'b11111, 5'b10100, 1, 32'hB2};
        tbl[6]  = '{1'b0, 5'b00000, 32'h0,  5'b00100, 5'b11111, 5'b00100, 1, 32'hB2};
        tbl[7]  = '{1'b0, 5'b00000, 32'h0,  5'b00000, 5'b00000, 5'b00000, 0, 32'hB2};
        tbl[8]  = '{1'b1, 5'b00110, 32'hC3, 5'b00000, 5'b00000, 5'b00000, 0, 32'hB2};
        tbl[9]  = '{1'b0, 5'b00000, 32'h0,  5'b00010, 5'b00000, 5'b00110, 1, 32'hC3};
        tbl[10] = '{1'b0, 5'b00000, 32'h0,  5'b00010, 5'b00000, 5'b00110, 1, 32'hC3};
        tbl[11] = '{1'b0, 5'b00000, 32'h0,  5'b00010, 5'b00000, 5'b00110, 1, 32'hC3};
        tbl[12] = '{1'b0, 5'b00000, 32'h0,  5'b00010, 5'b00010, 5'b00110, 1, 32'hC3};
        tbl[13] = '{1'b0, 5'b00000, 32'h0,  5'b00000, 5'b00000, 5'b00100, 1, 32'hC3};
        tbl[14] = '{1'b0, 5'b00000, 32'h0,  5'b00100, 5'b11111, 5'b00100, 1, 32'hC3};
        tbl[15] = '{1'b0, 5'b00000, 32'h0,  5'b00000, 5'b00000, 5'b00000, 0, 32'hC3};

        // Reset state while rst_n is still low.
        #1;
        chk("rst_arb_req", 64'(bus.arb_req), 64'd0);
        chk("rst_rdy", 64'(bus.ibuf_rdy), 64'd1);
        chk("rst_payload", 64'(bus.payload_o), 64'd0);
        chk("rst_occ", 64'(bus.occ), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: unicast, serial multicast, grant without obuf_rdy.
        for (int i = 0; i < 16; i++) begin
            sample(tbl[i].vld, tbl[i].route, tbl[i].pl, tbl[i].gnt, tbl[i].obuf);
            chk($sformatf("tbl%0d_arb", i), 64'(bus.arb_req), 64'(tbl[i].e_arb));
            chk($sformatf("tbl%0d_occ", i), 64'(bus.occ), 64'(tbl[i].e_occ));
            chk($sformatf("tbl%0d_pl", i), 64'(bus.payload_o), 64'(tbl[i].e_pl));
            chk($sformatf("tbl%0d_rdy", i), 64'(bus.ibuf_rdy), 64'd1);
            edge_step();
        end

        // Fill to DEPTH, refuse a fifth packet, then drain in order.
        for (int i = 0; i < DP; i++) begin
            apply(1'b1, dir_bit(dir_e'(i)), 32'hD0 + 32'(i), '0, '0);
        end
        sample(1'b1, 5'b10000, 32'hE4, '0, '0);
        chk("full_occ", 64'(bus.occ), 64'd4);
        chk("full_rdy", 64'(bus.ibuf_rdy), 64'd0);
        edge_step();
        sample(1'b0, '0, '0, 5'b00001, 5'b11111);
        chk("full_hold_occ", 64'(bus.occ), 64'd4);
        chk("full_hold_arb", 64'(bus.arb_req), 64'b00001);
        edge_step();
        sample(1'b0, '0, '0, '0, '0);
        chk("after_pop_rdy", 64'(bus.ibuf_rdy), 64'd1);
        chk("after_pop_occ", 64'(bus.occ), 64'd3);
        edge_step();
        for (int i = 1; i < DP; i++) begin
            sample(1'b0, '0, '0, dir_bit(dir_e'(i)), 5'b11111);
            chk($sformatf("order%0d_pl", i), 64'(bus.payload_o), 64'hD0 + 64'(i));
            chk($sformatf("order%0d_arb", i), 64'(bus.arb_req), 64'(dir_bit(dir_e'(i))));
            edge_step();
        end
        sample(1'b0, '0, '0, '0, '0);
        chk("drained_occ", 64'(bus.occ), 64'd0);
        edge_step();

        // Zero-mask packets are swallowed and the counter saturates.
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, '0, 32'(i), '0, '0);
        end
        sample(1'b0, '0, '0, '0, '0);
        chk("drop_sat", 64'(bus.drop_cnt), 64'd255);
        chk("drop_occ", 64'(bus.occ), 64'd0);
        edge_step();

        // Serve the single entry while a new one arrives: no bubble.
        apply(1'b1, 5'b10000, 32'hF0, '0, '0);
        sample(1'b1, 5'b01000, 32'hF1, 5'b10000, 5'b11111);
        chk("swap_arb0", 64'(bus.arb_req), 64'b10000);
        chk("swap_occ0", 64'(bus.occ), 64'd1);
        edge_step();
        sample(1'b0, '0, '0, '0, '0);
        chk("swap_arb1", 64'(bus.arb_req), 64'b01000);
        chk("swap_occ1", 64'(bus.occ), 64'd1);
        chk("swap_pl1", 64'(bus.payload_o), 64'hF1);
        edge_step();

        // Asynchronous reset in the middle of a cycle with entries stored.
        apply(1'b1, 5'b00011, 32'h77, '0, '0);
        @(negedge clk);
        bus.ibuf_vld = 1'b0;
        bus.arb_gnt  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_arb_req", 64'(bus.arb_req), 64'd0);
        chk("arst_rdy", 64'(bus.ibuf_rdy), 64'd1);
        chk("arst_payload", 64'(bus.payload_o), 64'd0);
        chk("arst_occ", 64'(bus.occ), 64'd0);
        chk("arst_drop", 64'(bus.drop_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 600; i++) begin
            logic [ND-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? '0 : ND'($urandom);
            apply(1'($urandom_range(0, 1)), r, $urandom, ND'($urandom), ND'($urandom | $urandom));
        end
        sample(1'b0, '0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ibuf_mc_fifo.md
# ibuf_mc_fifo

Parametrised multi-entry input buffer for one router input port of the mesh. Each accepted packet is stored with its output-direction request mask. The head entry requests its directions from the per-output arbiters. Multicast requests are granted one direction at a time, and the entry is released only after every requested direction has been served. The block replaces the single-entry input buffer between the link receiver/route-compute stage and the crossbar arbiters.

## Interface
- `PYLD_W`, default `` `PKT_W ``: payload width.
- `NDIR`, default 5: number of output directions. Bit order follows `` `DIR_N ``/`` `DIR_S ``/`` `DIR_E ``/`` `DIR_W ``/`` `DIR_B ``.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, default 8: width of the drop counter.
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ibuf_vld`, in, 1: upstream packet valid.
- `ibuf_rdy`, out, 1: buffer can accept a packet this cycle.
- `route_req`, in, NDIR: direction mask for the incoming packet. Multiple bits set means multicast.
- `payload_i`, in, PYLD_W: incoming payload.
- `arb_req`, out, NDIR: outstanding direction requests of the head entry.
- `arb_gnt`, in, NDIR: per-direction grant from the output arbiters.
- `obuf_rdy`, in, NDIR: per-direction output buffer ready.
- `payload_o`, out, PYLD_W: head-entry payload.
- `occ`, out, log2(DEPTH)+1: current number of stored entries.
- `drop_cnt`, out, CNT_W: saturating count of discarded zero-mask packets.

## Operation
- Push condition: `set = ibuf_vld & ibuf_rdy`.
  - If `set` and `route_req != 0`, store {route_req, payload_i} at `wr_ptr`, then increment `wr_ptr` and `occ`.
  - If `set` and `route_req == 0`, accept and discard the packet. `drop_cnt` increments and saturates at all-ones. No entry is stored.
- Serve condition: `clr = arb_gnt & obuf_rdy & arb_req`.
  - Grant bits outside `arb_req` are ignored.
  - A grant without the matching `obuf_rdy` bit clears nothing.
- Head mask `hd_mask`: register holding the directions still owed by the head entry. `arb_req = hd_mask` while `occ != 0`, otherwise 0.
  - Each cycle with no pop: `hd_mask <= hd_mask & ~clr`.
- Pop condition: `occ != 0` and `(hd_mask & ~clr) == 0`. On pop, `rd_ptr` increments and `hd_mask` reloads from the next entry:
  - From the stored route at `rd_ptr+1` if `occ ≥ 2`.
  - From `route_req` if `occ == 1` and a non-zero push happens in the same cycle.
  - To 0 otherwise.
- Push into an empty buffer loads `hd_mask` from `route_req` directly.
- `payload_o` is the head entry's payload, driven from the storage read at `rd_ptr`. It holds its last value when empty.
- Pointers wrap modulo DEPTH.
- `ibuf_rdy = (occ != DEPTH)`. It depends on registered state only, with no combinational path from `arb_gnt`/`obuf_rdy`. A full buffer accepts no push even in a cycle that pops.
- Push and pop in the same cycle leave `occ` unchanged.

## Timing
- Reset values: `arb_req=0`, `ibuf_rdy=1`, `payload_o=0`, `occ=0`, `drop_cnt=0`, pointers 0, `hd_mask=0`.
- Push-to-request latency is 1 cycle. A packet accepted at edge k drives `arb_req`/`payload_o` from edge k onward if the buffer was empty.
- Multicast with m requested bits takes at least m serve cycles only if the arbiters grant serially. Simultaneous grants clear their bits in the same cycle.
- After the last owed bit is served at edge k, the next entry's mask appears on `arb_req` at edge k. There are no bubble cycles.
- Reset asserted mid-operation immediately discards all entries and returns every output to its reset value, asynchronously.

## Structure
- Direction indices `` `DIR_* `` and `` `PKT_W `` stay in the shared param header.
- One sub-module, `ibuf_ram`: a DEPTH×(NDIR+PYLD_W) register array with one write port and one asynchronous read port. Pointer/count/mask control stays in the top module.

## Test plan
- Reset, then push one packet with route 00001 and `arb_gnt=obuf_rdy=00001` held → `arb_req=00001` for exactly 1 cycle, `occ` 1→0, `payload_o` equals the pushed value.
- Multicast route 10110, grants 00010 then 10000 then 00100 with `obuf_rdy` all 1 → `arb_req` 10110→10100→00100→0, and a single pop.
- Grant 00010 with `obuf_rdy=00000` for 3 cycles → `arb_req` unchanged. The bit clears in the first cycle `obuf_rdy[1]=1`.
- Push 4 packets with no grants (DEPTH=4) → `ibuf_rdy=0`, `occ=4`. A fifth `ibuf_vld` is not accepted. Serving the head raises `ibuf_rdy` on the following cycle, and order is preserved.
- Push with `route_req=0` 300 times (CNT_W=8) → `occ` stays 0, `drop_cnt` saturates at 255.
- With `occ=1`, serve the head while pushing route 01000 in the same cycle → `arb_req=01000` the next cycle, `occ` stays 1. Reset asserted mid-stream → all outputs at reset values asynchronously.
